core_frame_loader: RTL and testbench
====================================

# core_frame_loader

Core-side receiver for the scheduler-to-core instruction-frame interface; one instance per core. Captures the `INSN_LOAD_TIME` parts of an instruction frame streamed on the shared instruction bus, plus the optional R0 initial value. Commits the frame to the core pipeline and drives the core's `Ready` bit back to the scheduler. Also serves instruction fetches from the committed frame while the core runs.

## Interface

Parameters:
- `CORE_ID`, 0: index of this core in the `Start` / `Init_R0_Vect` / `Init_R0` vectors.
- `NUM_OF_CORES`, 16: number of cores on the shared bus.
- `INSN_LOAD_TIME`, 4: parts per frame.
- `INSN_BUS_WIDTH`, 64: bits per part.
- `INSN_WIDTH`, 16: bits per instruction. `INSN_LOAD_TIME*INSN_BUS_WIDTH` must be a multiple of `INSN_WIDTH`; `INSN_PER_FRAME` is the quotient.
- `REG_WIDTH`, 8: R0 width.

Ports:
- `clk` in 1: clock. Single clock domain.
- `reset` in 1: synchronous, active-high.
- `Start` in `NUM_OF_CORES`: per-core load strobe from the scheduler. This block uses bit `CORE_ID`.
- `Insn_Load_Counter` in clog2(`INSN_LOAD_TIME`): index of the part currently on `Insn_Data`.
- `Insn_Data` in `INSN_BUS_WIDTH`: frame part.
- `Init_R0_Vect` in `NUM_OF_CORES`: per-core R0-init enable.
- `Init_R0` in `NUM_OF_CORES*REG_WIDTH`: per-core R0 values; the field for core i is bits [i*REG_WIDTH +: REG_WIDTH].
- `Ready` out 1: to the scheduler; 1 = idle and able to accept a frame.
- `run` out 1: to the core; one-cycle pulse when execution of a new frame begins.
- `r0_we` out 1: to the core; one-cycle pulse, coincident with `run`, when R0 must be loaded.
- `r0_val` out `REG_WIDTH`: value to load into R0.
- `fetch_addr` in clog2(`INSN_PER_FRAME`): instruction index requested by the core.
- `fetch_insn` out `INSN_WIDTH`: committed instruction at `fetch_addr`.
- `core_done` in 1: from the core; the frame has finished executing.
- `seq_err` out 1: sticky protocol-violation flag.

## Operation

State machine: IDLE, LOAD, RUN.

- **IDLE** (`Ready`=1). A part is accepted when `Start[CORE_ID]`=1 and `Insn_Load_Counter`=0: store part 0 into staging and set `exp`=1. Go to LOAD, or go straight to commit if `INSN_LOAD_TIME`=1.
  - `Start[CORE_ID]`=1 with a nonzero counter: ignore the data and set `seq_err`.
- **LOAD** (`Ready`=1).
  - `Start[CORE_ID]`=1 and counter == `exp`: store the part into staging slot `exp`, then `exp`+1.
  - Counter != `exp`: discard staging, set `seq_err`, go to IDLE.
  - `Start[CORE_ID]`=0: discard staging, go to IDLE. No error; the scheduler may stall between frames only, never mid-frame.
  - Last part accepted (counter = `INSN_LOAD_TIME`-1): commit.
- **Commit** (same edge as the last part is captured):
  - Copy staging, including the part arriving this cycle, into the committed frame.
  - Latch `r0_val` from the `CORE_ID` field of `Init_R0`.
  - Latch `r0_pend` from `Init_R0_Vect[CORE_ID]`.
  - Go to RUN.
- **RUN** (`Ready`=0).
  - `run` and `r0_we`(=`r0_pend`) pulse on the first RUN cycle only.
  - `core_done`=1: go to IDLE.
  - `Start[CORE_ID]`=1 while in RUN: ignore and set `seq_err`.
  - `core_done` outside RUN: ignore.
- **Frame layout**: instruction k occupies frame bits [k*INSN_WIDTH +: INSN_WIDTH]. Part p occupies bits [p*INSN_BUS_WIDTH +: INSN_BUS_WIDTH].
- **Fetch**: `fetch_insn` is a combinational read of the committed frame. `fetch_addr` ≥ `INSN_PER_FRAME` returns 0 (NOP encoding). The committed frame changes only at commit, so it is stable throughout RUN.

## Timing

- Reset values:
  - `Ready`=1, `run`=0, `r0_we`=0, `r0_val`=0, `seq_err`=0.
  - State IDLE; committed frame and staging all-zero, so `fetch_insn`=0.
- Part p is sampled at the posedge where `Start[CORE_ID]`=1 and the counter equals p.
- Last part sampled at edge N:
  - `Ready`=0, `run`=1 and `r0_we` are valid in cycle N+1.
  - `fetch_insn` reflects the new frame from cycle N+1.
- `core_done` sampled at edge M: `Ready`=1 in cycle M+1. A new part 0 can be accepted at edge M+1.
- `core_done` in the same cycle as the `run` pulse is honoured. Zero-length execution gives `Ready` low for exactly 1 cycle.
- Reset asserted mid-LOAD or mid-RUN: back to reset values at the next edge; the pending frame is lost.
- `seq_err` clears only on reset.

## Structure

- Shared include, with the other range/width defines: frame-loader state encodings, the NOP value, and the `Init_R0` field macro (core index → bit range). The latter is shared with the scheduler.
- Sub-module `insn_frame_buf`:
  - Holds the staging and committed registers.
  - Part write port.
  - Commit strobe.
  - Combinational fetch mux.
- The FSM, error flag and R0 latch stay in the top module.

## Test plan

Defaults unless stated: `CORE_ID`=2, `INSN_LOAD_TIME`=4, `INSN_BUS_WIDTH`=64, `INSN_WIDTH`=16.

- **Full load:** `Start[2]`=1 for 4 cycles, counter 0..3, parts 0x0001_0002_0003_0004 … 0x000D_000E_000F_0010 → `Ready` falls 1 cycle after the last part. `fetch_insn`(addr 0)=0x0004 and (addr 15)=0x000D. `run` is high for one cycle.
- **R0 init:** `Init_R0_Vect`=0x0004, core-2 field of `Init_R0`=0xA5 → `r0_we`=1 and `r0_val`=0xA5, coincident with `run`. Repeat with `Init_R0_Vect`=0 → `r0_we` stays 0.
- **Done handshake:** `core_done` pulse 10 cycles into RUN → `Ready`=1 on the next cycle. A second frame loads and the old frame content is fully replaced.
- **Out-of-order part:** counter sequence 0,1,3 → `seq_err`=1, `Ready` stays 1, no `run`, committed frame unchanged.
- **Start in RUN and other cores' strobes:** `Start[2]`=1 during RUN → ignored and `seq_err`=1. `Start[5]` strobes at any time → no effect on this core.
- **Reset mid-load:** reset after part 2 → all outputs at reset values, `fetch_insn`=0. A following full load succeeds.

Source files
------------

// File: rtl/core_frame_loader_pkg.sv
// Shared definitions for the core-side instruction frame loader: state encodings,
// the NOP instruction value and the Init_R0 field helper shared with the scheduler.
package core_frame_loader_pkg;

  typedef enum logic [1:0] {
    FL_IDLE = 2'd0,
    FL_LOAD = 2'd1,
    FL_RUN  = 2'd2
  } fl_state_e;

  localparam int unsigned FL_NOP = 0;

  // Low bit of core i's field inside the packed Init_R0 vector.
  function automatic int unsigned init_r0_lsb(input int unsigned core_idx,
                                              input int unsigned reg_w);
    return core_idx * reg_w;
  endfunction

  // Index width for n entries, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_frame_loader_frame_buf.sv
// Staging and committed instruction frame registers with a combinational fetch mux.
// Commit copies staging merged with the part arriving in the same cycle.
module insn_frame_buf
  import core_frame_loader_pkg::*;
#(
  parameter  int unsigned INSN_LOAD_TIME = 4,
  parameter  int unsigned INSN_BUS_WIDTH = 64,
  parameter  int unsigned INSN_WIDTH     = 16,
  parameter  int unsigned CNT_W          = 2,
  parameter  int unsigned ADDR_W         = 4,
  localparam int unsigned FRAME_W        = INSN_LOAD_TIME * INSN_BUS_WIDTH,
  localparam int unsigned INSN_PER_FRAME = FRAME_W / INSN_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_part_we,
  input  logic [CNT_W-1:0]          i_part_idx,
  input  logic [INSN_BUS_WIDTH-1:0] i_part_data,
  input  logic                      i_commit,
  input  logic                      i_clear,
  input  logic [ADDR_W-1:0]         i_fetch_addr,
  output logic [INSN_WIDTH-1:0]     o_fetch_insn
);

  logic [INSN_LOAD_TIME-1:0][INSN_BUS_WIDTH-1:0] r_stage;
  logic [INSN_LOAD_TIME-1:0][INSN_BUS_WIDTH-1:0] w_merged;
  logic [FRAME_W-1:0]                            r_frame;
  logic [INSN_WIDTH-1:0]                         w_insn_tab [2**ADDR_W];

  always_comb begin
    w_merged = r_stage;
    if (i_part_we) w_merged[i_part_idx] = i_part_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage <= '0;
      r_frame <= '0;
    end else begin
      if (i_clear)        r_stage <= '0;
      else if (i_part_we) r_stage <= w_merged;
      if (i_commit)       r_frame <= w_merged;
    end
  end

  // Addresses beyond the frame read as NOP.
  for (genvar k = 0; k < 2**ADDR_W; k++) begin : g_tab
    if (k < INSN_PER_FRAME) begin : g_insn
      assign w_insn_tab[k] = r_frame[k*INSN_WIDTH +: INSN_WIDTH];
    end else begin : g_nop
      assign w_insn_tab[k] = INSN_WIDTH'(FL_NOP);
    end
  end

  assign o_fetch_insn = w_insn_tab[i_fetch_addr];

endmodule

// File: rtl/core_frame_loader.sv
// Per-core receiver for scheduler instruction frames: collects parts, commits the frame,
// pulses run/r0_we and reports Ready and sticky protocol errors.
//
// state   | meaning
// FL_IDLE | Ready=1, waiting for part 0 on this core's Start bit
// FL_LOAD | Ready=1, collecting parts 1..INSN_LOAD_TIME-1 in order
// FL_RUN  | Ready=0, core executing committed frame until core_done
module core_frame_loader
  import core_frame_loader_pkg::*;
#(
  parameter  int unsigned CORE_ID        = 0,
  parameter  int unsigned NUM_OF_CORES   = 16,
  parameter  int unsigned INSN_LOAD_TIME = 4,
  parameter  int unsigned INSN_BUS_WIDTH = 64,
  parameter  int unsigned INSN_WIDTH     = 16,
  parameter  int unsigned REG_WIDTH      = 8,
  localparam int unsigned INSN_PER_FRAME = INSN_LOAD_TIME * INSN_BUS_WIDTH / INSN_WIDTH,
  localparam int unsigned CNT_W          = idx_w(INSN_LOAD_TIME),
  localparam int unsigned ADDR_W         = idx_w(INSN_PER_FRAME)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_OF_CORES-1:0]           Start,
  input  logic [CNT_W-1:0]                  Insn_Load_Counter,
  input  logic [INSN_BUS_WIDTH-1:0]         Insn_Data,
  input  logic [NUM_OF_CORES-1:0]           Init_R0_Vect,
  input  logic [NUM_OF_CORES*REG_WIDTH-1:0] Init_R0,
  output logic                              Ready,
  output logic                              run,
  output logic                              r0_we,
  output logic [REG_WIDTH-1:0]              r0_val,
  input  logic [ADDR_W-1:0]                 fetch_addr,
  output logic [INSN_WIDTH-1:0]             fetch_insn,
  input  logic                              core_done,
  output logic                              seq_err
);

  localparam int unsigned     R0_LSB    = init_r0_lsb(CORE_ID, REG_WIDTH);
  localparam logic [CNT_W-1:0] LAST_PART = CNT_W'(INSN_LOAD_TIME - 1);

  fl_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_exp, w_exp_nxt;
  logic             r_run, r_r0_pend, r_seq_err;
  logic [REG_WIDTH-1:0] r_r0_val;
  logic             w_start, w_part_we, w_commit, w_clear, w_err_set;

  assign w_start = Start[CORE_ID];

  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_exp;
    w_part_we   = 1'b0;
    w_commit    = 1'b0;
    w_clear     = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      FL_IDLE: begin
        if (w_start) begin
          if (Insn_Load_Counter == '0) begin
            w_part_we = 1'b1;
            w_exp_nxt = CNT_W'(1);
            if (INSN_LOAD_TIME == 1) begin
              w_commit    = 1'b1;
              w_state_nxt = FL_RUN;
            end else begin
              w_state_nxt = FL_LOAD;
            end
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      FL_LOAD: begin
        // A stall mid-frame is an abandoned frame, not an error.
        if (!w_start) begin
          w_clear     = 1'b1;
          w_state_nxt = FL_IDLE;
        end else if (Insn_Load_Counter != r_exp) begin
          w_clear     = 1'b1;
          w_err_set   = 1'b1;
          w_state_nxt = FL_IDLE;
        end else begin
          w_part_we = 1'b1;
          if (r_exp == LAST_PART) begin
            w_commit    = 1'b1;
            w_state_nxt = FL_RUN;
          end else begin
            w_exp_nxt = r_exp + 1'b1;
          end
        end
      end
      FL_RUN: begin
        if (w_start)   w_err_set   = 1'b1;
        if (core_done) w_state_nxt = FL_IDLE;
      end
      default: w_state_nxt = FL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FL_IDLE;
      r_exp     <= '0;
      r_run     <= 1'b0;
      r_r0_pend <= 1'b0;
      r_r0_val  <= '0;
      r_seq_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_exp   <= w_exp_nxt;
      r_run   <= w_commit;
      if (w_commit) begin
        r_r0_pend <= Init_R0_Vect[CORE_ID];
        r_r0_val  <= Init_R0[R0_LSB +: REG_WIDTH];
      end
      if (w_err_set) r_seq_err <= 1'b1;
    end
  end

  insn_frame_buf #(
    .INSN_LOAD_TIME (INSN_LOAD_TIME),
    .INSN_BUS_WIDTH (INSN_BUS_WIDTH),
    .INSN_WIDTH     (INSN_WIDTH),
    .CNT_W          (CNT_W),
    .ADDR_W         (ADDR_W)
  ) u_frame_buf (
    .clk          (clk),
    .reset        (reset),
    .i_part_we    (w_part_we),
    .i_part_idx   (Insn_Load_Counter),
    .i_part_data  (Insn_Data),
    .i_commit     (w_commit),
    .i_clear      (w_clear),
    .i_fetch_addr (fetch_addr),
    .o_fetch_insn (fetch_insn)
  );

  assign Ready   = (r_state != FL_RUN);
  assign run     = r_run;
  assign r0_we   = r_run & r_r0_pend;
  assign r0_val  = r_r0_val;
  assign seq_err = r_seq_err;

endmodule

// File: tb/tb_core_frame_loader.sv
// Scoreboard bench for core_frame_loader (core 2 of 16, four 64-bit parts, 16-bit insns).
module tb_core_frame_loader;

  localparam int CID = 2;
  localparam int RW  = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  Start;
  logic [1:0]   Insn_Load_Counter;
  logic [63:0]  Insn_Data;
  logic [15:0]  Init_R0_Vect;
  logic [127:0] Init_R0;
  logic         Ready, run, r0_we;
  logic [7:0]   r0_val;
  logic [3:0]   fetch_addr;
  logic [15:0]  fetch_insn;
  logic         core_done, seq_err;

  core_frame_loader #(
    .CORE_ID(CID), .NUM_OF_CORES(16), .INSN_LOAD_TIME(4),
    .INSN_BUS_WIDTH(64), .INSN_WIDTH(16), .REG_WIDTH(RW)
  ) dut (
    .clk(clk), .reset(reset), .Start(Start), .Insn_Load_Counter(Insn_Load_Counter),
    .Insn_Data(Insn_Data), .Init_R0_Vect(Init_R0_Vect), .Init_R0(Init_R0),
    .Ready(Ready), .run(run), .r0_we(r0_we), .r0_val(r0_val),
    .fetch_addr(fetch_addr), .fetch_insn(fetch_insn), .core_done(core_done),
    .seq_err(seq_err)
  );

  always #50 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic       we;
    logic [7:0] val;
  } r0_exp_t;

  r0_exp_t sb_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every run pulse must match the next committed frame's R0 expectation.
  always @(posedge clk) begin : mon
    r0_exp_t e;
    #2;
    if (run) begin
      if (sb_q.size() == 0) begin
        check_val("run_unexpected", run, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check_val("r0_we", r0_we, e.we);
        check_val("r0_val", r0_val, e.val);
      end
    end else begin
      check_val("r0_we_idle", r0_we, 1'b0);
    end
  end

  function automatic logic [63:0] part_val(input int f, input int p);
    int b;
    b = f * 64 + p * 4;
    return {16'(b + 1), 16'(b + 2), 16'(b + 3), 16'(b + 4)};
  endfunction

  function automatic logic [255:0] frame_val(input int f);
    logic [255:0] fr;
    for (int p = 0; p < 4; p++) fr[p*64 +: 64] = part_val(f, p);
    return fr;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Other cores' strobes toggle randomly; only bit CID is controlled.
  task automatic drive_start(input logic b);
    Start      = 16'($urandom()) & 16'hFFFB;
    Start[CID] = b;
  endtask

  task automatic check_frame(input logic [255:0] fr);
    for (int a = 0; a < 16; a++) begin
      fetch_addr = 4'(a);
      #2;
      check_val($sformatf("fetch%0d", a), fetch_insn, fr[a*16 +: 16]);
    end
  endtask

  task automatic check_reset();
    check_val("rst_ready", Ready, 1'b1);
    check_val("rst_run", run, 1'b0);
    check_val("rst_r0_we", r0_we, 1'b0);
    check_val("rst_r0_val", r0_val, 8'h00);
    check_val("rst_seq_err", seq_err, 1'b0);
    check_val("rst_fetch", fetch_insn, 16'h0000);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_start(1'b0);
    step();
    reset = 1'b0;
    check_reset();
  endtask

  task automatic send_part(input int f, input int p, input int cnt);
    Insn_Load_Counter = 2'(cnt);
    Insn_Data         = part_val(f, p);
    drive_start(1'b1);
    step();
  endtask

  task automatic load_frame(input int f, input logic vect, input logic [7:0] r0v,
                            input logic zero_len);
    Init_R0_Vect      = 16'($urandom());
    Init_R0_Vect[CID] = vect;
    Init_R0           = {$urandom(), $urandom(), $urandom(), $urandom()};
    Init_R0[CID*RW +: RW] = r0v;
    for (int p = 0; p < 4; p++) begin
      if (p == 3) sb_q.push_back(r0_exp_t'{we: vect, val: r0v});
      send_part(f, p, p);
      if (p < 3) check_val("ready_load", Ready, 1'b1);
    end
    check_val("ready_commit", Ready, 1'b0);
    check_val("run_pulse", run, 1'b1);
    drive_start(1'b0);
    Init_R0_Vect = 16'($urandom());
    Init_R0      = {$urandom(), $urandom(), $urandom(), $urandom()};
    if (zero_len) core_done = 1'b1;
    step();
    core_done = 1'b0;
    check_val("run_once", run, 1'b0);
    if (zero_len) check_val("ready_zero_len", Ready, 1'b1);
    else          check_val("ready_run", Ready, 1'b0);
    check_frame(frame_val(f));
  endtask

  task automatic finish_run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check_val("ready_in_run", Ready, 1'b0);
      step();
    end
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    check_val("ready_after_done", Ready, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    Start = '0;
    Insn_Load_Counter = '0;
    Insn_Data = '0;
    Init_R0_Vect = '0;
    Init_R0 = '0;
    fetch_addr = '0;
    core_done = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_reset();

    // core_done while idle is ignored
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    check_val("done_idle_ready", Ready, 1'b1);

    // Full load with R0 init, fixed-value fetch spots, done 10 cycles into RUN
    load_frame(0, 1'b1, 8'hA5, 1'b0);
    fetch_addr = 4'd0;
    #2 check_val("fetch_a0", fetch_insn, 16'h0004);
    fetch_addr = 4'd15;
    #2 check_val("fetch_a15", fetch_insn, 16'h000D);
    finish_run(8);

    // Second frame without R0 init fully replaces the first
    load_frame(1, 1'b0, 8'h3C, 1'b0);
    finish_run(3);

    // Zero-length execution
    load_frame(2, 1'b1, 8'h5A, 1'b1);
    check_val("seq_err_clean", seq_err, 1'b0);

    // Start during RUN is ignored but flagged
    load_frame(3, 1'b0, 8'h00, 1'b0);
    Insn_Load_Counter = 2'd0;
    Insn_Data = part_val(9, 0);
    drive_start(1'b1);
    step();
    check_val("start_run_err", seq_err, 1'b1);
    check_val("start_run_ready", Ready, 1'b0);
    drive_start(1'b0);
    step();
    check_val("start_run_norun", run, 1'b0);
    check_frame(frame_val(3));
    finish_run(2);

    // Out-of-order part after a clean frame
    do_reset();
    load_frame(5, 1'b1, 8'h11, 1'b0);
    finish_run(1);
    send_part(6, 0, 0);
    send_part(6, 1, 1);
    check_val("ooo_pre_err", seq_err, 1'b0);
    send_part(6, 3, 3);
    check_val("ooo_err", seq_err, 1'b1);
    check_val("ooo_ready", Ready, 1'b1);
    drive_start(1'b0);
    step();
    check_val("ooo_ready2", Ready, 1'b1);
    check_frame(frame_val(5));

    // Reset mid-load, then a full load succeeds
    do_reset();
    send_part(7, 0, 0);
    send_part(7, 1, 1);
    send_part(7, 2, 2);
    Insn_Load_Counter = 2'd3;
    Insn_Data = part_val(7, 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive_start(1'b0);
    check_reset();
    check_frame('0);
    load_frame(8, 1'b1, 8'h77, 1'b0);
    finish_run(1);

    // Mid-frame stall abandons the frame without an error
    send_part(9, 0, 0);
    send_part(9, 1, 1);
    drive_start(1'b0);
    step();
    step();
    check_val("stall_err", seq_err, 1'b0);
    check_val("stall_ready", Ready, 1'b1);
    check_frame(frame_val(8));
    load_frame(10, 1'b0, 8'h42, 1'b0);
    finish_run(1);

    step();
    check_val("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
